// File: rtl/origin_cost_sched_if.sv
// Handshake and bus bundle between the origin-cost scheduler and its neighbours:
// frame control, left census stream, right line-buffer read port and cost stream.
interface origin_cost_sched_if #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned MAX_DISP = 64,
  parameter int unsigned CENSUS_W = 16,
  parameter int unsigned COST_W   = $clog2(CENSUS_W + 1)
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned DW = $clog2(MAX_DISP);

  logic                start;
  logic                busy;
  logic                done;
  logic                pix_valid;
  logic                pix_ready;
  logic [CENSUS_W-1:0] left_census;
  logic                rd_en;
  logic [XW-1:0]       rd_addr;
  logic [CENSUS_W-1:0] rd_data;
  logic                cost_valid;
  logic                cost_ready;
  logic [COST_W-1:0]   cost_data;
  logic [DW-1:0]       cost_disp;
  logic [XW-1:0]       cost_x;
  logic [YW-1:0]       cost_y;
  logic                cost_last;

  // Scheduler side.
  modport slave (
    input  start, pix_valid, left_census, rd_data, cost_ready,
    output busy, done, pix_ready, rd_en, rd_addr,
           cost_valid, cost_data, cost_disp, cost_x, cost_y, cost_last
  );

  // Environment side (pixel source, right line buffer, aggregation sink).
  modport master (
    output start, pix_valid, left_census, rd_data, cost_ready,
    input  busy, done, pix_ready, rd_en, rd_addr,
           cost_valid, cost_data, cost_disp, cost_x, cost_y, cost_last
  );
endinterface

// File: rtl/origin_cost_sched.sv
// Origin matching-cost scheduler: sweeps d = 0..MAX_DISP-1 per left pixel, reads the right
// census at x-d and streams Hamming costs through a 2-entry FIFO to the aggregation stage.
module origin_cost_sched #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned MAX_DISP = 64,
  parameter int unsigned CENSUS_W = 16,
  parameter int unsigned COST_W   = $clog2(CENSUS_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  origin_cost_sched_if.slave   bus
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned DW = $clog2(MAX_DISP);

  typedef enum logic [1:0] {StIdle, StWaitPix, StSweep, StDrain} state_e;

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [DW-1:0]     disp;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              last;
  } beat_t;

  state_e              r_state, w_state_nxt;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [DW-1:0]       r_d;
  logic [CENSUS_W-1:0] r_left;

  // Slot issued last cycle; its right census arrives this cycle.
  logic                r_if_vld;
  logic                r_if_border;
  logic                r_if_last;
  logic [DW-1:0]       r_if_d;
  logic [XW-1:0]       r_if_x;
  logic [YW-1:0]       r_if_y;

  beat_t               r_mem [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_cnt;

  logic                w_pop, w_permit, w_issue, w_border, w_pix_hs;
  logic                w_last_d, w_last_x, w_last_y;
  logic [CENSUS_W-1:0] w_xor;
  logic [COST_W-1:0]   w_ones, w_cost;
  beat_t               w_head, w_push_beat;

  assign w_pop    = (r_cnt != 2'd0) && bus.cost_ready;
  // Counting the slot in flight keeps FIFO occupancy bounded without waiting on cost_ready.
  assign w_permit = ({1'b0, r_cnt} + {2'b00, r_if_vld} - {2'b00, w_pop}) < 3'd2;
  assign w_issue  = (r_state == StSweep) && w_permit;
  assign w_border = 32'(r_x) < 32'(r_d);
  assign w_pix_hs = (r_state == StWaitPix) && bus.pix_valid;
  assign w_last_d = r_d == DW'(MAX_DISP - 1);
  assign w_last_x = r_x == XW'(IMG_W - 1);
  assign w_last_y = r_y == YW'(IMG_H - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.busy      = (r_state != StIdle);
    bus.pix_ready = (r_state == StWaitPix);
    bus.done      = 1'b0;
    bus.rd_en     = w_issue && !w_border;
    bus.rd_addr   = bus.rd_en ? (r_x - XW'(r_d)) : '0;
    unique case (r_state)
      StIdle:    if (bus.start) w_state_nxt = StWaitPix;
      StWaitPix: if (bus.pix_valid) w_state_nxt = StSweep;
      StSweep: begin
        if (w_issue && w_last_d) w_state_nxt = (w_last_x && w_last_y) ? StDrain : StWaitPix;
      end
      StDrain: begin
        if ((r_cnt == 2'd0) && !r_if_vld) begin
          bus.done    = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_d    <= '0;
      r_left <= '0;
    end else if (r_state == StIdle) begin
      r_x <= '0;
      r_y <= '0;
      r_d <= '0;
    end else if (w_pix_hs) begin
      r_left <= bus.left_census;
      r_d    <= '0;
    end else if (w_issue) begin
      if (w_last_d) begin
        r_d <= '0;
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end else begin
        r_d <= r_d + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_vld    <= 1'b0;
      r_if_border <= 1'b0;
      r_if_last   <= 1'b0;
      r_if_d      <= '0;
      r_if_x      <= '0;
      r_if_y      <= '0;
    end else begin
      r_if_vld <= w_issue;
      if (w_issue) begin
        r_if_border <= w_border;
        r_if_last   <= w_last_d;
        r_if_d      <= r_d;
        r_if_x      <= r_x;
        r_if_y      <= r_y;
      end
    end
  end

  assign w_xor = r_left ^ bus.rd_data;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < CENSUS_W; i++) w_ones = w_ones + COST_W'(w_xor[i]);
  end

  assign w_cost      = r_if_border ? COST_W'(CENSUS_W) : w_ones;
  assign w_push_beat = '{cost: w_cost, disp: r_if_d, x: r_if_x, y: r_if_y, last: r_if_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (r_if_vld) begin
        r_mem[r_wr_ptr] <= w_push_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, r_if_vld} - {1'b0, w_pop};
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign bus.cost_valid = (r_cnt != 2'd0);
  assign bus.cost_data  = bus.cost_valid ? w_head.cost : '0;
  assign bus.cost_disp  = bus.cost_valid ? w_head.disp : '0;
  assign bus.cost_x     = bus.cost_valid ? w_head.x    : '0;
  assign bus.cost_y     = bus.cost_valid ? w_head.y    : '0;
  assign bus.cost_last  = bus.cost_valid && w_head.last;
endmodule

// File: tb/tb_origin_cost_sched.sv
// Bench for origin_cost_sched: random/directed frames on a 4x2 image with 4 disparities,
// compared beat-by-beat and read-by-read against a reference computed from the cost rules.
module tb_origin_cost_sched;
  localparam int W = 4, H = 2, D = 4, CW = 16;
  localparam int NPIX = W * H, NBEAT = NPIX * D;

  logic clk = 1'b0;
  logic rst_n;

  origin_cost_sched_if #(.IMG_W(W), .IMG_H(H), .MAX_DISP(D), .CENSUS_W(CW)) bus ();

  origin_cost_sched #(.IMG_W(W), .IMG_H(H), .MAX_DISP(D), .CENSUS_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] lpix [NPIX];
  logic [15:0] rmem [W];
  bit          src_rand = 1'b0;
  int          src_idx  = 0;

  int          n_chk = 0, n_pass = 0, n_fail = 0;

  // Monitor-owned records of the current frame.
  int          cyc = 0;
  logic [31:0] got_q [$];
  logic [7:0]  rd_q [$];
  int          hs_cyc [$];
  int          first_cv = -1, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
  int          stab_err = 0, deny_err = 0;

  function automatic logic [31:0] pk(input int y, input int x, input int d, input int c,
                                     input bit l);
    return {y[7:0], x[7:0], d[7:0], 2'b00, l, c[4:0]};
  endfunction

  function automatic logic [17:0] outs();
    return {bus.busy, bus.done, bus.pix_ready, bus.rd_en, bus.cost_valid, bus.cost_last,
            bus.rd_addr, bus.cost_data, bus.cost_disp, bus.cost_x, bus.cost_y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Right line buffer: data appears the cycle after the strobe; garbage otherwise.
  initial begin
    bit         en;
    logic [1:0] a;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      en = bus.rd_en;
      a  = bus.rd_addr;
      @(posedge clk);
      #1;
      bus.rd_data = en ? rmem[a] : 16'($urandom);
    end
  end

  // Left pixel source: offers pixels in raster order, restarts whenever the DUT is idle.
  initial begin
    bit hs, b;
    bus.pix_valid   = 1'b0;
    bus.left_census = '0;
    forever begin
      @(negedge clk);
      hs = bus.pix_valid && bus.pix_ready;
      b  = bus.busy;
      @(posedge clk);
      #1;
      if (!b) src_idx = 0;
      else if (hs) src_idx++;
      bus.pix_valid   = (src_idx < NPIX) && (!src_rand || $urandom_range(0, 1) == 1);
      bus.left_census = lpix[src_idx % NPIX];
    end
  end

  initial begin
    logic [31:0] pbeat;
    bit          pv = 1'b0, pr = 1'b0;
    int          low = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv  = 1'b0;
        low = 0;
      end else begin
        if (bus.start && !bus.busy) begin
          got_q.delete();
          rd_q.delete();
          hs_cyc.delete();
          first_cv = -1;
          done_cnt = 0;
          stab_err = 0;
          deny_err = 0;
        end
        if (pv && !pr && !(bus.cost_valid && pk(int'(bus.cost_y), int'(bus.cost_x),
            int'(bus.cost_disp), int'(bus.cost_data), bus.cost_last) == pbeat))
          stab_err++;
        low = bus.cost_ready ? 0 : low + 1;
        if (low >= 3 && bus.rd_en) deny_err++;
        if (bus.rd_en) rd_q.push_back(8'(bus.rd_addr));
        if (bus.pix_valid && bus.pix_ready) hs_cyc.push_back(cyc);
        if (bus.cost_valid && first_cv < 0) first_cv = cyc;
        if (bus.cost_valid && bus.cost_ready) begin
          got_q.push_back(pk(int'(bus.cost_y), int'(bus.cost_x), int'(bus.cost_disp),
                             int'(bus.cost_data), bus.cost_last));
          last_hs_cyc = cyc;
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        pv    = bus.cost_valid;
        pr    = bus.cost_ready;
        pbeat = pk(int'(bus.cost_y), int'(bus.cost_x), int'(bus.cost_disp),
                   int'(bus.cost_data), bus.cost_last);
      end
    end
  end

  task automatic check_frame(input string nm, input bit timing);
    logic [31:0] exp_b [$];
    logic [7:0]  exp_r [$];
    int          bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int d = 0; d < D; d++) begin
          if (x < d) exp_b.push_back(pk(y, x, d, CW, d == D - 1));
          else begin
            exp_b.push_back(pk(y, x, d, $countones(lpix[y*W+x] ^ rmem[x-d]), d == D - 1));
            exp_r.push_back(8'(x - d));
          end
        end
    chk({nm, "_beat_count"}, 64'(got_q.size()), 64'(NBEAT));
    foreach (exp_b[i])
      chk($sformatf("%s_beat%0d", nm, i), (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx,
          exp_b[i]);
    chk({nm, "_rd_count"}, 64'(rd_q.size()), 64'(exp_r.size()));
    foreach (exp_r[i])
      chk($sformatf("%s_rd%0d", nm, i), (i < rd_q.size()) ? rd_q[i] : 8'hxx, exp_r[i]);
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, "_done_timing"}, 64'(done_cyc), 64'(last_hs_cyc + 1));
    chk({nm, "_busy_after"}, 64'(bus.busy), 64'd0);
    chk({nm, "_pix_ready_after"}, 64'(bus.pix_ready), 64'd0);
    chk({nm, "_stall_stable"}, 64'(stab_err), 64'd0);
    chk({nm, "_rd_while_denied"}, 64'(deny_err), 64'd0);
    if (timing) begin
      chk({nm, "_hs_count"}, 64'(hs_cyc.size()), 64'(NPIX));
      chk({nm, "_latency"}, 64'(first_cv - ((hs_cyc.size() > 0) ? hs_cyc[0] : 0)), 64'd3);
      for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != D + 1) bad++;
      chk({nm, "_pix_spacing_bad"}, 64'(bad), 64'd0);
    end
  endtask

  // mode: 0 plain, 1 backpressure gap, 2 random ready, 3 extra start while busy
  task automatic run_frame(input string nm, input int mode);
    int i;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk({nm, "_busy_latency"}, 64'(bus.busy), 64'd1);
    chk({nm, "_pix_ready_latency"}, 64'(bus.pix_ready), 64'd1);
    if (mode == 1) begin
      for (i = 0; i < 500 && got_q.size() < 5; i++) begin @(posedge clk); #1; end
      bus.cost_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (k >= 2) begin
          chk($sformatf("%s_bp_rd_en%0d", nm, k), 64'(bus.rd_en), 64'd0);
          chk($sformatf("%s_bp_valid%0d", nm, k), 64'(bus.cost_valid), 64'd1);
        end
        @(posedge clk); #1;
      end
      bus.cost_ready = 1'b1;
    end
    if (mode == 2) begin
      for (i = 0; i < 3000 && done_cnt == 0; i++) begin
        @(posedge clk); #1;
        bus.cost_ready = ($urandom_range(0, 2) != 0);
      end
      bus.cost_ready = 1'b1;
    end
    if (mode == 3) begin
      repeat (8) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    i = 0;
    while (done_cnt == 0 && i < 3000) begin @(negedge clk); i++; end
    chk({nm, "_frame_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int i;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.cost_ready = 1'b0;
    for (int k = 0; k < NPIX; k++) lpix[k] = 16'hF0F0;
    for (int k = 0; k < W; k++) rmem[k] = 16'h0F0F;
    #1;
    chk("reset_outputs", 64'(outs()), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 64'(outs()), 64'd0);

    bus.cost_ready = 1'b1;
    run_frame("basic", 0);
    check_frame("basic", 1'b1);

    for (int k = 0; k < NPIX; k++) lpix[k] = 16'h0001;
    for (int k = 0; k < W; k++) rmem[k] = 16'h0000;
    run_frame("lat", 3);
    check_frame("lat", 1'b1);
    chk("lat_first_cost", 64'((got_q.size() > 0) ? got_q[0] : 32'd0), 64'(pk(0, 0, 0, 1, 0)));

    for (int k = 0; k < NPIX; k++) lpix[k] = 16'($urandom);
    for (int k = 0; k < W; k++) rmem[k] = 16'($urandom);
    run_frame("bp", 1);
    check_frame("bp", 1'b0);

    for (int k = 0; k < NPIX; k++) lpix[k] = 16'($urandom);
    for (int k = 0; k < W; k++) rmem[k] = 16'($urandom);
    src_rand = 1'b1;
    run_frame("rnd", 2);
    check_frame("rnd", 1'b0);
    src_rand = 1'b0;

    // Abort at pixel (2,0), d=1 and confirm the next frame starts clean.
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (i = 0; i < 500 && !(bus.rd_en && bus.rd_addr == 2'd1 && src_idx == 3); i++)
      @(negedge clk);
    chk("rst_point_reached", 64'(i < 500), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'(outs()), 64'd0);
    chk("rst_mid_cost_valid", 64'(bus.cost_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    chk("rst_idle_outputs", 64'(outs()), 64'd0);

    for (int k = 0; k < NPIX; k++) lpix[k] = 16'($urandom);
    for (int k = 0; k < W; k++) rmem[k] = 16'($urandom);
    run_frame("post_rst", 0);
    check_frame("post_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
